// File: rtl/alu_serial_pkg.sv
// Shared definitions for the digit-serial ALU.
//   OP_*    : operation encoding carried on the 2-bit op port
//   state_t : controller state encoding (S_IDLE, S_BUSY, S_DONE)
package alu_serial_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_serial_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from one-bit full-adder
// cells.
//   x, y : addend digits
//   cin  : carry into bit 0
//   sum  : DIGIT-bit sum
//   cout : carry out of the top bit
module alu_digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[DIGIT];

endmodule

// File: rtl/alu_serial.sv
// Handshaked, width-generic ALU whose adder processes DIGIT bits per clock.
// Each operation is reduced to X + Y + cin (mod 2^WIDTH):
//   ADD: A + B   INC: B + 1   NEG: -A   SUB: B - A
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (op, A, B sampled on accept)
//   op, A, B             : operation and operands
//   out_valid / out_ready: result handshake
//   out, Z, N, C, V      : result and flags, held until the next result
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("alu_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic               carry_q;
    logic [WIDTH-1:0]   res_q;

    logic [WIDTH-1:0]   op_x;
    logic [WIDTH-1:0]   op_y;
    logic               op_cin;
    logic [31:0]        dig_base;
    logic [DIGIT-1:0]   dig_x;
    logic [DIGIT-1:0]   dig_y;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic [WIDTH-1:0]   res_new;
    logic               accept;

    // Map the requested operation onto a single adder form X + Y + cin.
    always_comb begin
        op_x   = A;
        op_y   = B;
        op_cin = 1'b0;
        case (op)
            OP_ADD: begin
                op_x   = A;
                op_y   = B;
                op_cin = 1'b0;
            end
            OP_INC: begin
                op_x   = '0;
                op_y   = B;
                op_cin = 1'b1;
            end
            OP_NEG: begin
                op_x   = ~A;
                op_y   = '0;
                op_cin = 1'b1;
            end
            OP_SUB: begin
                op_x   = ~A;
                op_y   = B;
                op_cin = 1'b1;
            end
            default: begin
                op_x   = A;
                op_y   = B;
                op_cin = 1'b0;
            end
        endcase
    end

    assign dig_base = 32'(cnt_q) * 32'(DIGIT);
    assign dig_x    = x_q[dig_base +: DIGIT];
    assign dig_y    = y_q[dig_base +: DIGIT];

    alu_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x    (dig_x),
        .y    (dig_y),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // Result register with the current digit merged in; on the last digit
    // this is the complete result, so flags are derived from it directly.
    always_comb begin
        res_new                     = res_q;
        res_new[dig_base +: DIGIT]  = dig_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == LAST_DIGIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign accept = (state_q == S_IDLE) && in_valid;

    // Operand registers carry no reset: they are always loaded on accept
    // before they are consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= op_x;
            y_q <= op_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            out     <= '0;
            Z       <= 1'b1;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            carry_q <= op_cin;
            res_q   <= '0;
        end else if (state_q == S_BUSY) begin
            res_q   <= res_new;
            carry_q <= dig_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_DIGIT) begin
                out <= res_new;
                Z   <= (res_new == '0);
                N   <= res_new[WIDTH-1];
                C   <= dig_cout;
                // Operands agree in sign but the result does not.
                V   <= (x_q[WIDTH-1] == y_q[WIDTH-1]) &&
                       (res_new[WIDTH-1] != x_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Same four operations (ADD, INC, NEG, SUB) with identical arithmetic semantics.
- Width is generic, and the add is digit-serial: DIGIT bits per clock. This trades latency for area.
- Adds registered carry and overflow flags alongside Z/N. It sits between the register file and the writeback path of the lab datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- DIGIT, 8, bits processed per cycle; WIDTH % DIGIT == 0 is required, and other values are an elaboration error.
- NUM_DIGITS, WIDTH/DIGIT, derived local constant; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept a new operation
- op  input  2  operation: 00 ADD, 01 INC, 10 NEG, 11 SUB
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result
- Z  output  1  result == 0
- N  output  1  result MSB
- C  output  1  carry out of MSB
- V  output  1  signed overflow

Behaviour:
- Arithmetic, with X, Y and cin chosen per op, then X + Y + cin mod 2^WIDTH:
  - ADD: X=A, Y=B, cin=0, giving A+B.
  - INC: X=0, Y=B, cin=1, giving B+1.
  - NEG: X=~A, Y=0, cin=1, giving -A.
  - SUB: X=~A, Y=B, cin=1, giving B-A.
- States are IDLE, BUSY and DONE (reset state IDLE).
- IDLE:
  - in_ready=1.
  - If in_valid, the block latches X, Y and cin, clears the digit counter and the result register, and goes to BUSY.
  - Operands are sampled only on the accepting edge; later changes on A/B/op are ignored.
- BUSY:
  - in_ready=0.
  - Each edge adds digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of X and Y plus the carry register, writes the sum slice into the result register, updates the carry register and increments k.
  - After digit NUM_DIGITS-1 the block goes to DONE.
- Latency: out_valid rises exactly NUM_DIGITS cycles after the accepting cycle. With DIGIT=WIDTH this is 1 cycle.
- DONE:
  - out_valid=1. out and the flags stay stable until out_ready is seen.
  - out_ready=1 returns the block to IDLE on that edge. out_valid is 0 the next cycle, and in_ready is 1.
  - A new operation cannot be accepted in the same cycle as the result handoff.
- Flags are registered when the block enters DONE:
  - Z: result == 0.
  - N: result[WIDTH-1].
  - C: final carry register.
  - V: (X[MSB] == Y[MSB]) && (result[MSB] != X[MSB]).
- out, Z, N, C and V hold their last values in IDLE/BUSY. Consumers qualify them with out_valid only.
- Reset values:
  - State IDLE.
  - in_ready=1 (combinational from state).
  - out_valid=0.
  - out=0, Z=1 (consistent with out=0), N=0, C=0, V=0.
  - Counter=0, carry=0.
- Reset asserted in BUSY or DONE aborts the operation. The result is discarded, outputs take their reset values on that edge, and no out_valid pulse follows.
- out_valid and in_ready are never both 1.

Decomposition:
- Package alu_serial_pkg holds:
  - op encoding constants OP_ADD=2'b00, OP_INC=2'b01, OP_NEG=2'b10, OP_SUB=2'b11;
  - state encoding constants S_IDLE, S_BUSY, S_DONE (2 bits).
- Sub-module alu_digit_adder is a combinational DIGIT-bit ripple adder:
  - inputs x[DIGIT], y[DIGIT], cin;
  - outputs sum[DIGIT], cout;
  - built from one-bit full-adder cells and instantiated once.
- The FSM, counter, operand and result registers live in alu_serial.

Test Plan (WIDTH=32, DIGIT=8 unless noted):
- ADD 0x0000_0005 + 0x0000_0003, out_ready=1 → out_valid 4 cycles after accept; out=0x0000_0008, Z=0, N=0, C=0, V=0. The next cycle out_valid=0 and in_ready=1.
- SUB A=5, B=3 → out=0xFFFF_FFFE, N=1, Z=0, C=0.
- SUB A=B=0x1234_5678 → out=0, Z=1, C=1.
- INC B=0xFFFF_FFFF → out=0, Z=1, C=1, V=0.
- INC B=0x7FFF_FFFF → out=0x8000_0000, N=1, V=1.
- NEG A=0x8000_0000 → out=0x8000_0000, N=1, V=1.
- Handshake and abort:
  - out_ready=0 for 5 cycles after DONE → out_valid and out stay stable, and in_valid pulses are ignored (in_ready=0).
  - rst asserted on the 2nd BUSY cycle → the next cycle is IDLE with out_valid=0, out=0, Z=1 and no later result.
- Parameter sweep: for DIGIT=32 and DIGIT=1, run 1000 random ops against a reference model. Latency must be 1 and 32 cycles respectively, with all results and flags matching.
